// File: rtl/rr_pkg.sv
// Shared round-robin definitions: default sizes and the queue-pointer width helper.
// Both the dispatch (writer) side and the round-robin reader side use this package.
package rr_pkg;

  localparam int RR_QUEUE_QUANTITY = 4;
  localparam int RR_DATA_BITS      = 8;
  localparam int RR_STALL_CNT_BITS = 16;

  // Pointer width for n queues (clog2, never less than 1 bit).
  function automatic int ptr_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first non-full queue starting at ptr, wrapping at N-1.
// Purely combinational.
module rr_pick
  import rr_pkg::*;
#(
  parameter int N  = RR_QUEUE_QUANTITY,
  parameter int PW = ptr_w(RR_QUEUE_QUANTITY)
) (
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  buf_full,
  output logic [PW-1:0] sel,
  output logic          found
);

  int idx;

  // Walk from the farthest candidate back to ptr so the nearest free queue wins last.
  always_comb begin
    sel   = ptr;
    found = ~(&buf_full);
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!buf_full[idx]) sel = PW'(idx);
    end
  end

endmodule

// File: rtl/rr_dispatch.sv
// Round-robin dispatcher: one-entry holding register feeding N destination FIFOs,
// rotating start pointer, stall indication and a saturating stall-cycle counter.
module rr_dispatch
  import rr_pkg::*;
#(
  parameter int QUEUE_QUANTITY = RR_QUEUE_QUANTITY,
  parameter int DATA_BITS      = RR_DATA_BITS,
  parameter int STALL_CNT_BITS = RR_STALL_CNT_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enb,
  input  logic                                 in_valid,
  input  logic [DATA_BITS-1:0]                 in_data,
  output logic                                 in_ready,
  input  logic [QUEUE_QUANTITY-1:0]            buf_full,
  output logic [QUEUE_QUANTITY-1:0]            push,
  output logic [DATA_BITS-1:0]                 push_data,
  output logic [ptr_w(QUEUE_QUANTITY)-1:0]     dest,
  output logic                                 stall,
  output logic [STALL_CNT_BITS-1:0]            stall_cycles
);

  localparam int PW = ptr_w(QUEUE_QUANTITY);

  logic                      held_q, held_d;
  logic [DATA_BITS-1:0]      data_q, data_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [STALL_CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

  logic [PW-1:0] sel;
  logic          found;
  logic          fire;
  logic          accept;

  function automatic logic [STALL_CNT_BITS-1:0] sat_inc(input logic [STALL_CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rr_pick #(
    .N  (QUEUE_QUANTITY),
    .PW (PW)
  ) u_pick (
    .ptr      (ptr_q),
    .buf_full (buf_full),
    .sel      (sel),
    .found    (found)
  );

  // Handshake, push strobes and next-state; every output is forced quiet while rst is high.
  always_comb begin
    fire        = held_q & enb & found & ~rst;
    in_ready    = (~held_q | fire) & ~rst;
    accept      = in_valid & in_ready;
    stall       = held_q & enb & ~found & ~rst;

    push        = '0;
    if (fire) push[sel] = 1'b1;
    push_data   = data_q;
    dest        = rst ? '0 : (fire ? sel : ptr_q);

    held_d      = accept | (held_q & ~fire);
    data_d      = accept ? in_data : data_q;
    ptr_d       = ptr_q;
    if (fire) ptr_d = (sel == PW'(QUEUE_QUANTITY - 1)) ? '0 : sel + 1'b1;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;

    stall_cycles = stall_cnt_q;
  end

  // Control state with synchronous reset; a held word is simply dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q      <= 1'b0;
      ptr_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      held_q      <= held_d;
      ptr_q       <= ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Holding data register; only meaningful while held_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: doc/rr_dispatch.md
RR_DISPATCH -- requirements
Module: rr_dispatch

Interface
REQ-001 Parameter QUEUE_QUANTITY SHALL be provided: default 4; number of destination queues, 2..16, non-power-of-2 allowed.
REQ-002 Parameter DATA_BITS SHALL be provided: default 8; word width.
REQ-003 Parameter STALL_CNT_BITS SHALL be provided: default 16; width of the stall counter.
REQ-004 Port clk SHALL be: input, 1 bit, clock; all state updates on rising edge.
REQ-005 Port rst SHALL be: input, 1 bit, reset, synchronous, active-high.
REQ-006 Port enb SHALL be: input, 1 bit, dispatch enable.
REQ-007 Port in_valid SHALL be: input, 1 bit, upstream word valid.
REQ-008 Port in_data SHALL be: input, DATA_BITS, upstream word.
REQ-009 Port in_ready SHALL be: output, 1 bit, block accepts in_data this cycle.
REQ-010 Port buf_full SHALL be: input, QUEUE_QUANTITY bits, per-queue FIFO full flag.
REQ-011 Port push SHALL be: output, QUEUE_QUANTITY bits, one-hot FIFO write strobe.
REQ-012 Port push_data SHALL be: output, DATA_BITS, word written to the strobed FIFO.
REQ-013 Port dest SHALL be: output, clog2(QUEUE_QUANTITY) bits, index of the strobed queue.
REQ-014 Port stall SHALL be: output, 1 bit, word held but no queue can take it.
REQ-015 Port stall_cycles SHALL be: output, STALL_CNT_BITS, saturating count of stall cycles.

Function
REQ-016 The block SHALL contain a one-entry holding register (data and held flag) and a rotating pointer ptr.
REQ-017 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; the word SHALL be loaded into the holding register and held set.
REQ-018 in_ready SHALL be (!held | fire) & !rst, with fire = held & enb & (buf_full != all ones).
REQ-019 sel SHALL be the first index i in the order ptr, ptr+1, ..., wrapping QUEUE_QUANTITY-1 to 0, with buf_full[i]=0.
REQ-020 When fire=1, push SHALL equal one-hot(sel), dest SHALL equal sel, and push_data SHALL equal the held word, all combinational in the same cycle.
REQ-021 When fire=0, push SHALL be all zeros, dest SHALL equal ptr, and push_data SHALL equal the held word.
REQ-022 On a fire edge, ptr SHALL become sel+1, or 0 when sel=QUEUE_QUANTITY-1; otherwise ptr SHALL hold.
REQ-023 On a fire edge, held SHALL clear unless a new word is accepted on the same edge; on simultaneous fire and accept, held SHALL stay 1 with the new data.
REQ-024 Latency from acceptance edge to push assertion SHALL be 1 cycle minimum; back-to-back throughput SHALL be 1 word per cycle.
REQ-025 stall SHALL equal held & enb & (buf_full == all ones).
REQ-026 stall_cycles SHALL increment on each edge where stall=1 and saturate at all ones.
REQ-027 With enb=0: no push, ptr frozen, the held word retained, in_ready = !held.
REQ-028 buf_full bits of non-selected queues SHALL NOT affect ptr.

Reset
REQ-029 While rst=1: held=0, ptr=0, stall_cycles=0; push=0, in_ready=0, stall=0, dest=0.
REQ-030 Reset asserted mid-operation SHALL discard any held word without pushing it.
REQ-031 The first acceptance after reset SHALL be possible on the first edge with rst=0.

Structure
REQ-032 Shared package rr_pkg SHALL hold the default QUEUE_QUANTITY, DATA_BITS and STALL_CNT_BITS, and the pointer-width function (clog2), shared with the round-robin reader side.
REQ-033 The rotating-priority search SHALL be a sub-module rr_pick (inputs ptr, buf_full; outputs sel, found), purely combinational.
REQ-034 The holding register, ptr and stall counter SHALL reside in rr_dispatch.

Verification (QUEUE_QUANTITY=4 unless stated)
REQ-035 After reset, 0xA1..0xA5 back-to-back with buf_full=0000 -> pushes to q0,q1,q2,q3,q0 on consecutive cycles, each one cycle after its acceptance; in_ready stays 1.
REQ-036 ptr=1, buf_full=0010, held 0x3C -> push=0100, dest=2, push_data=0x3C; ptr becomes 3.
REQ-037 ptr=0, held 0x77, buf_full=1111 for 5 cycles -> push=0, in_ready=0, stall=1, stall_cycles=5; then buf_full=0111 -> push=1000, dest=3, ptr becomes 0.
REQ-038 Held 0x12, enb=0 for 3 cycles -> push=0, ptr unchanged, in_ready=0; enb=1 -> push to q[ptr].
REQ-039 Held 0x55 and stall_cycles=9, rst pulsed 1 cycle -> no push, held=0, ptr=0, stall_cycles=0; next cycle in_ready=1.
REQ-040 QUEUE_QUANTITY=3, 4 words with buf_full=000 -> dest sequence 0,1,2,0; ptr never reaches 3.
